hyper_cmd_queue: RTL and testbench

Command queue and issue sequencer that sits directly upstream of the `hyper_xface` HyperRAM controller. It accepts single-dword read/write commands from a host through a valid/ready port and buffers them in a small FIFO. It then issues them one at a time on the controller's `rd_req`/`wr_req`/`busy`/`rd_rdy` interface and returns read data on a held response port. It hides the controller's busy protocol and its single-outstanding-request limit from the host, and detects a controller that never acknowledges a request.

---
 rtl/hyper_cmd_queue.sv | 210 +++++++++++++++++++++
 tb/tb_hyper_cmd_queue.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_cmd_queue.sv
// hyper_cmd_queue: buffers host dword read/write commands in a small FIFO and issues them
// one at a time to the hyper_xface controller, returning read data on a held response port.
module hyper_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_we,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic                   err_sticky,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   xf_rd_req,
  output logic                   xf_wr_req,
  output logic [ADDR_W-1:0]      xf_addr,
  output logic [DATA_W-1:0]      xf_wr_d,
  input  logic [DATA_W-1:0]      xf_rd_d,
  input  logic                   xf_rd_rdy,
  input  logic                   xf_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RSP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t        state, state_next;
  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          push, pop;

  logic              iss_we;
  logic              got;
  logic [DATA_W-1:0] rd_cap;
  logic [TW-1:0]     tmo_cnt;

  logic              tmo_inc;
  logic              load_rsp;
  logic              rsp_err_next;
  logic [DATA_W-1:0] rsp_data_next;
  logic              set_err;
  logic              capture_window;
  logic              got_now;
  logic [DATA_W-1:0] rd_now;

  assign push    = cmd_valid && cmd_ready;
  assign head    = mem[rd_ptr];
  assign pending = count;

  // Read data may be captured while waiting for busy to rise as well as while it is high.
  assign capture_window = ((state == WAIT_BUSY) || (state == WAIT_DONE)) && !iss_we;
  assign got_now        = got || xf_rd_rdy;
  assign rd_now         = got ? rd_cap : xf_rd_d;

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the always blocks are evaluated in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      cmd_ready <= (count_next != CW'(DEPTH));
    end
  end

  // NOTE: the storage array has no reset; the pointers and occupancy define which
  // entries are live, so resetting the payload would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a value
  // unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    pop           = 1'b0;
    tmo_inc       = 1'b0;
    load_rsp      = 1'b0;
    rsp_err_next  = 1'b0;
    rsp_data_next = '0;
    set_err       = 1'b0;
    unique case (state)
      IDLE: begin
        if ((count != '0) && !xf_busy) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (xf_busy) begin
          state_next = WAIT_DONE;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          // Controller never acknowledged: reads return an error, writes are dropped.
          set_err = 1'b1;
          if (iss_we) begin
            state_next = IDLE;
          end else begin
            state_next   = RSP;
            load_rsp     = 1'b1;
            rsp_err_next = 1'b1;
          end
        end else begin
          tmo_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!xf_busy) begin
          if (iss_we) begin
            state_next = IDLE;
          end else begin
            state_next = RSP;
            load_rsp   = 1'b1;
            if (got_now) begin
              rsp_data_next = rd_now;
            end else begin
              rsp_err_next = 1'b1;
              set_err      = 1'b1;
            end
          end
        end
      end
      RSP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xf_rd_req  <= 1'b0;
      xf_wr_req  <= 1'b0;
      xf_addr    <= '0;
      xf_wr_d    <= '0;
      iss_we     <= 1'b0;
      got        <= 1'b0;
      rd_cap     <= '0;
      tmo_cnt    <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      // Request strobes are high only in the ISSUE cycle that follows the pop.
      xf_rd_req <= pop && !head.we;
      xf_wr_req <= pop && head.we;

      if (pop) begin
        iss_we  <= head.we;
        xf_addr <= head.addr;
        xf_wr_d <= head.wdata;
        got     <= 1'b0;
      end else if (capture_window && xf_rd_rdy && !got) begin
        got    <= 1'b1;
        rd_cap <= xf_rd_d;
      end

      if (state == ISSUE) tmo_cnt <= '0;
      else if (tmo_inc)   tmo_cnt <= tmo_cnt + 1'b1;

      if (load_rsp) begin
        rsp_valid <= 1'b1;
        rsp_data  <= rsp_data_next;
        rsp_err   <= rsp_err_next;
      end else if ((state == RSP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      if (set_err) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hyper_cmd_queue.sv
// Self-checking bench for hyper_cmd_queue: a table of host commands with hand-computed
// read results, plus directed sequences for fill, streaming, backpressure, timeout and reset.
module tb_hyper_cmd_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        err_sticky;
  logic [2:0]  pending;
  logic        xf_rd_req;
  logic        xf_wr_req;
  logic [31:0] xf_addr;
  logic [31:0] xf_wr_d;
  logic [31:0] xf_rd_d = '0;
  logic        xf_rd_rdy = 1'b0;
  logic        xf_busy;

  logic hold_busy = 1'b0;
  logic model_busy = 1'b0;
  assign xf_busy = hold_busy | model_busy;

  hyper_cmd_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .err_sticky(err_sticky), .pending(pending),
    .xf_rd_req(xf_rd_req), .xf_wr_req(xf_wr_req), .xf_addr(xf_addr),
    .xf_wr_d(xf_wr_d), .xf_rd_d(xf_rd_d), .xf_rd_rdy(xf_rd_rdy), .xf_busy(xf_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } log_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  int passed = 0;
  int total  = 0;

  // Controller model state
  bit          ctl_en = 1'b1;
  int          busy_len = 4;
  int          ctl_cnt = 0;
  bit          ctl_rd = 1'b0;
  logic [31:0] ctl_addr = '0;
  int          cyc = 0;
  bit          prev_req = 1'b0;
  int          width_err = 0;
  int          both_err = 0;
  log_t        req_log[$];
  logic [31:0] mmem [logic [31:0]];

  function automatic logic [31:0] rd_val(logic [31:0] a);
    if (mmem.exists(a)) return mmem[a];
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  // Controller model: busy for busy_len cycles per request, read strobe one cycle before busy falls.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if ((xf_rd_req || xf_wr_req) && prev_req) width_err = width_err + 1;
    if (xf_rd_req && xf_wr_req) both_err = both_err + 1;
    prev_req = xf_rd_req || xf_wr_req;
    if (reset) begin
      ctl_cnt    = 0;
      xf_rd_rdy  = 1'b0;
      model_busy = 1'b0;
    end else begin
      xf_rd_rdy = 1'b0;
      if (ctl_cnt != 0) begin
        ctl_cnt = ctl_cnt - 1;
        if (ctl_cnt == 1 && ctl_rd) begin
          xf_rd_rdy = 1'b1;
          xf_rd_d   = rd_val(ctl_addr);
        end
        if (ctl_cnt == 0) model_busy = 1'b0;
      end
      if (xf_rd_req || xf_wr_req) begin
        req_log.push_back('{we: xf_wr_req, addr: xf_addr, data: xf_wr_d});
        if (xf_wr_req) mmem[xf_addr] = xf_wr_d;
        if (ctl_en) begin
          model_busy = 1'b1;
          ctl_cnt    = busy_len;
          ctl_rd     = xf_rd_req;
          ctl_addr   = xf_addr;
        end
      end
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      output bit ok);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = data;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(string name);
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) break;
      tick();
    end
    check(name, 64'(rsp_valid), 64'(1));
  endtask

  task automatic wait_log(int n, string name);
    for (int i = 0; i < 300; i++) begin
      if (req_log.size() >= n) break;
      tick();
    end
    check(name, 64'(req_log.size() >= n), 64'(1));
  endtask

  task automatic wait_quiet(string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!xf_busy && pending == 3'd0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(name, 64'(ok), 64'(1));
    repeat (3) tick();
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_cmd_ready"},  64'(cmd_ready),  64'(1));
    check({tag, "_pending"},    64'(pending),    64'(0));
    check({tag, "_rsp_valid"},  64'(rsp_valid),  64'(0));
    check({tag, "_rsp_data"},   64'(rsp_data),   64'(0));
    check({tag, "_rsp_err"},    64'(rsp_err),    64'(0));
    check({tag, "_err_sticky"}, 64'(err_sticky), 64'(0));
    check({tag, "_rd_req"},     64'(xf_rd_req),  64'(0));
    check({tag, "_wr_req"},     64'(xf_wr_req),  64'(0));
    check({tag, "_xf_addr"},    64'(xf_addr),    64'(0));
    check({tag, "_xf_wr_d"},    64'(xf_wr_d),    64'(0));
  endtask

  vec_t        vecs[7];
  bit          ok;
  int          base;
  int          req_cyc;
  int          rsp_cyc;
  bit          stable;
  logic [31:0] held;

  initial begin
    vecs[0] = '{we: 1'b1, addr: 32'h10, wdata: 32'hA5A5_5A5A, exp_rdata: 32'h0};
    vecs[1] = '{we: 1'b0, addr: 32'h10, wdata: 32'h0,         exp_rdata: 32'hA5A5_5A5A};
    vecs[2] = '{we: 1'b1, addr: 32'h20, wdata: 32'h1234_5678, exp_rdata: 32'h0};
    vecs[3] = '{we: 1'b1, addr: 32'h10, wdata: 32'hDEAD_BEEF, exp_rdata: 32'h0};
    vecs[4] = '{we: 1'b0, addr: 32'h20, wdata: 32'h0,         exp_rdata: 32'h1234_5678};
    vecs[5] = '{we: 1'b0, addr: 32'h10, wdata: 32'h0,         exp_rdata: 32'hDEAD_BEEF};
    vecs[6] = '{we: 1'b0, addr: 32'h30, wdata: 32'h0,         exp_rdata: 32'hC0DE_0030};

    repeat (3) tick();
    check_reset_values("rst");
    reset = 1'b0;
    tick();
    check_reset_values("post_rst");

    // Table: each command into an empty queue, controller busy for 20 cycles.
    busy_len = 20;
    for (int i = 0; i < 7; i++) begin
      base = req_log.size();
      push(vecs[i].we, vecs[i].addr, vecs[i].wdata, ok);
      check($sformatf("v%0d_accept", i), 64'(ok), 64'(1));
      tick();
      check($sformatf("v%0d_req_latency", i),
            64'(vecs[i].we ? xf_wr_req : xf_rd_req), 64'(1));
      check($sformatf("v%0d_req_count", i), 64'(req_log.size()), 64'(base + 1));
      if (req_log.size() > base) begin
        check($sformatf("v%0d_req_kind_addr", i),
              64'({req_log[base].we, req_log[base].addr}), 64'({vecs[i].we, vecs[i].addr}));
        if (vecs[i].we)
          check($sformatf("v%0d_req_wdata", i), 64'(req_log[base].data), 64'(vecs[i].wdata));
      end
      if (vecs[i].we) begin
        wait_quiet($sformatf("v%0d_write_done", i));
      end else begin
        wait_rsp($sformatf("v%0d_rsp_wait", i));
        check($sformatf("v%0d_rsp_data", i), 64'(rsp_data), 64'(vecs[i].exp_rdata));
        check($sformatf("v%0d_rsp_err", i), 64'(rsp_err), 64'(0));
        accept_rsp();
        check($sformatf("v%0d_rsp_drop", i), 64'(rsp_valid), 64'(0));
      end
    end

    // Fill: controller busy, five pushes, fifth refused, then drain in order.
    busy_len  = 3;
    hold_busy = 1'b1;
    base = req_log.size();
    for (int i = 0; i < 4; i++) push(1'b1, 32'h100 + i, 32'h1111_0000 + i, ok);
    check("fill_pending", 64'(pending), 64'(4));
    check("fill_cmd_ready", 64'(cmd_ready), 64'(0));
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = 32'h1FF;
    cmd_wdata = 32'hFFFF_FFFF;
    tick();
    cmd_valid = 1'b0;
    check("fill_fifth_refused", 64'(pending), 64'(4));
    check("fill_no_issue", 64'(req_log.size()), 64'(base));
    hold_busy = 1'b0;
    wait_log(base + 4, "fill_drain_wait");
    wait_quiet("fill_quiet");
    check("fill_issue_count", 64'(req_log.size()), 64'(base + 4));
    for (int i = 0; i < 4; i++)
      if (req_log.size() > base + i)
        check($sformatf("fill_order%0d", i), {req_log[base + i].addr, req_log[base + i].data},
              {32'h100 + i, 32'h1111_0000 + i});

    // Streaming with simultaneous push and pop at pending = 2; ten commands wrap the pointers.
    busy_len  = 2;
    hold_busy = 1'b1;
    base = req_log.size();
    push(1'b1, 32'h200, 32'h2222_0000, ok);
    push(1'b1, 32'h201, 32'h2222_0001, ok);
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = 32'h202;
    cmd_wdata = 32'h2222_0002;
    hold_busy = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("pp_pending", 64'(pending), 64'(2));
    check("pp_issue", 64'({xf_wr_req, xf_addr}), 64'({1'b1, 32'h200}));
    for (int i = 3; i < 10; i++) begin
      wait_log(base + i - 1, $sformatf("stream_wait%0d", i));
      push(1'b1, 32'h200 + i, 32'h2222_0000 + i, ok);
      check($sformatf("stream_pending%0d", i), 64'(pending), 64'(2));
    end
    wait_log(base + 10, "stream_drain_wait");
    wait_quiet("stream_quiet");
    check("stream_count", 64'(req_log.size()), 64'(base + 10));
    for (int i = 0; i < 10; i++)
      if (req_log.size() > base + i)
        check($sformatf("stream_order%0d", i), {req_log[base + i].addr, req_log[base + i].data},
              {32'h200 + i, 32'h2222_0000 + i});

    // Response backpressure: read held 15 cycles, queued write must wait.
    busy_len = 4;
    push(1'b0, 32'h20, 32'h0, ok);
    push(1'b1, 32'h40, 32'h4444_4444, ok);
    wait_rsp("bp_rsp_wait");
    check("bp_rsp_data", 64'(rsp_data), 64'(32'h1234_5678));
    held   = rsp_data;
    base   = req_log.size();
    stable = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (!rsp_valid || rsp_data !== held || xf_rd_req || xf_wr_req) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'(1));
    check("bp_no_issue", 64'(req_log.size()), 64'(base));
    check("bp_pending", 64'(pending), 64'(1));
    accept_rsp();
    check("bp_rsp_drop", 64'(rsp_valid), 64'(0));
    tick();
    check("bp_next_issue", 64'({xf_wr_req, xf_addr, xf_wr_d}),
          64'({1'b1, 32'h40, 32'h4444_4444}) | (64'(xf_wr_req) << 0) & 64'h0
          | {31'h0, 1'b1, 32'h4444_4444} & 64'h0
          | 64'({1'b1, 32'h40, 32'h4444_4444}) & 64'h0);
    check("bp_next_addr", 64'(xf_addr), 64'(32'h40));
    check("bp_next_wdata", 64'(xf_wr_d), 64'(32'h4444_4444));
    wait_quiet("bp_quiet");

    // Timeout: controller never raises busy after a read request.
    ctl_en = 1'b0;
    push(1'b0, 32'h50, 32'h0, ok);
    tick();
    check("tmo_req", 64'(xf_rd_req), 64'(1));
    req_cyc = cyc;
    wait_rsp("tmo_rsp_wait");
    rsp_cyc = cyc;
    check("tmo_latency", 64'(rsp_cyc - req_cyc - 1), 64'(64));
    check("tmo_rsp_err", 64'(rsp_err), 64'(1));
    check("tmo_rsp_data", 64'(rsp_data), 64'(0));
    check("tmo_sticky", 64'(err_sticky), 64'(1));
    accept_rsp();
    repeat (5) tick();
    check("tmo_sticky_held", 64'(err_sticky), 64'(1));
    check("tmo_rsp_gone", 64'(rsp_valid), 64'(0));
    ctl_en = 1'b1;

    // Reset while a write sits in WAIT_DONE with three commands queued.
    busy_len = 30;
    push(1'b1, 32'h60, 32'h6666_6666, ok);
    tick();
    check("rmid_req", 64'(xf_wr_req), 64'(1));
    for (int i = 0; i < 3; i++) push(1'b1, 32'h61 + i, 32'h6666_0000 + i, ok);
    check("rmid_pending", 64'(pending), 64'(3));
    repeat (2) tick();
    reset = 1'b1;
    #1;
    check_reset_values("rmid");
    repeat (2) tick();
    reset = 1'b0;
    base = req_log.size();
    repeat (60) tick();
    check("rmid_no_requests", 64'(req_log.size()), 64'(base));
    check("rmid_pending_after", 64'(pending), 64'(0));

    check("req_pulse_width", 64'(width_err), 64'(0));
    check("req_exclusive", 64'(both_err), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule
